// File: rtl/control_fsm.sv
// control_fsm: multi-cycle fetch/decode/exec/mem/wb sequencer with req/ack memory handshakes.
// Define CTRL_PERF_CNT_EN to add the retired_cnt/stall_cnt performance counters.
module control_fsm #(
  parameter int INST_W    = 9,
  parameter int REG_IDX_W = 4,
  parameter int KEY_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INST_W-1:0]    inst,
  input  logic                 inst_ack,
  input  logic                 mem_ack,
  input  logic                 z,
  input  logic                 c,
  input  logic                 n,
  input  logic                 v,
  output logic                 inst_req,
  output logic                 pc_inc,
  output logic                 branch_en,
  output logic [KEY_W-1:0]     key,
  output logic                 memory_read_en,
  output logic                 memory_write_en,
  output logic                 reg_write_en,
  output logic [REG_IDX_W-1:0] reg_write_number,
  output logic [REG_IDX_W-1:0] reg_from_number,
  output logic                 reg_to_reg,
  output logic                 fetch_acc_en,
  output logic                 halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          retired_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [3:0]        f_q, f_d;          // {z, c, n, v}
  logic              active_q, active_d;
  logic              unused_flag_v;

  logic                 is_br, is_acc, is_halt, is_load, is_store, is_mv_to, is_mv_from, taken;
  logic [2:0]           sub;
  logic [3:0]           op;
  logic [REG_IDX_W-1:0] idx;

  assign unused_flag_v = f_q[0];

  assign is_br      = ir_q[INST_W-1];
  assign sub        = ir_q[INST_W-2 -: 3];
  assign op         = ir_q[INST_W-2 -: 4];
  assign idx        = ir_q[REG_IDX_W-1:0];
  assign is_acc     = is_br && (sub == 3'b100);
  assign is_halt    = is_br && (sub == 3'b111);
  assign is_load    = !is_br && (op == 4'b0000);
  assign is_store   = !is_br && (op == 4'b0001);
  assign is_mv_to   = !is_br && (op == 4'b1100);
  assign is_mv_from = !is_br && (op == 4'b1101);

  always_comb begin
    taken = 1'b0;
    case (sub)
      3'b000:  taken = f_q[1] & ~f_q[3];
      3'b001:  taken = ~f_q[1] & ~f_q[3];
      3'b010:  taken = f_q[3];
      3'b011:  taken = 1'b1;
      3'b101:  taken = ~f_q[3];
      3'b110:  taken = f_q[2];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    f_d              = f_q;
    active_d         = 1'b1;
    inst_req         = 1'b0;
    pc_inc           = 1'b0;
    branch_en        = 1'b0;
    memory_read_en   = 1'b0;
    memory_write_en  = 1'b0;
    reg_write_en     = 1'b0;
    reg_write_number = '0;
    reg_from_number  = '0;
    reg_to_reg       = 1'b0;
    fetch_acc_en     = 1'b0;
    halted           = 1'b0;
    case (state_q)
      // active_q keeps the request low until the first edge after reset releases
      S_FETCH: begin
        if (active_q) begin
          inst_req = 1'b1;
          if (inst_ack) begin
            ir_d    = inst;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        f_d     = {z, c, n, v};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_acc) begin
          fetch_acc_en = 1'b1;
          reg_write_en = 1'b1;
          pc_inc       = 1'b1;
        end else if (is_br) begin
          branch_en = taken;
          pc_inc    = !taken;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          reg_write_en = 1'b1;
          pc_inc       = 1'b1;
          if (is_mv_to) begin
            reg_to_reg       = 1'b1;
            reg_write_number = idx;
          end else begin
            reg_to_reg      = is_mv_from;
            reg_from_number = idx;
          end
        end
      end
      S_MEM: begin
        memory_read_en  = is_load;
        memory_write_en = is_store;
        reg_from_number = idx;
        if (mem_ack) begin
          // STORE retires in its ack cycle, so this one strobe follows mem_ack directly
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_inc  = !reset;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        pc_inc       = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    key = (branch_en || fetch_acc_en) ? ir_q[KEY_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      f_q      <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      f_q      <= f_d;
      active_q <= active_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q, retired_d, stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (pc_inc || branch_en)
      retired_d = retired_q + 32'd1;
    if ((inst_req && !inst_ack) || ((memory_read_en || memory_write_en) && !mem_ack))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm: each task drives one scenario cycle by cycle.
module tb_control_fsm;
  localparam int INST_W    = 9;
  localparam int REG_IDX_W = 4;
  localparam int KEY_W     = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [INST_W-1:0]    inst;
  logic                 inst_ack, mem_ack, z, c, n, v;
  logic                 inst_req, pc_inc, branch_en;
  logic [KEY_W-1:0]     key;
  logic                 memory_read_en, memory_write_en, reg_write_en;
  logic [REG_IDX_W-1:0] reg_write_number, reg_from_number;
  logic                 reg_to_reg, fetch_acc_en, halted;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0]          retired_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [21:0] outs;
  assign outs = {inst_req, pc_inc, branch_en, key, memory_read_en, memory_write_en,
                 reg_write_en, reg_write_number, reg_from_number, reg_to_reg,
                 fetch_acc_en, halted};

  always #5 clk = ~clk;

  control_fsm #(.INST_W(INST_W), .REG_IDX_W(REG_IDX_W), .KEY_W(KEY_W)) dut (
    .clk(clk), .reset(reset), .inst(inst), .inst_ack(inst_ack), .mem_ack(mem_ack),
    .z(z), .c(c), .n(n), .v(v),
    .inst_req(inst_req), .pc_inc(pc_inc), .branch_en(branch_en), .key(key),
    .memory_read_en(memory_read_en), .memory_write_en(memory_write_en),
    .reg_write_en(reg_write_en), .reg_write_number(reg_write_number),
    .reg_from_number(reg_from_number), .reg_to_reg(reg_to_reg),
    .fetch_acc_en(fetch_acc_en), .halted(halted)
`ifdef CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents an instruction with ack in the current FETCH cycle; returns in DECODE.
  task automatic fetch(input logic [INST_W-1:0] i);
    inst     = i;
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    inst     = '1;
  endtask

  task automatic test_reset();
    reset = 1'b1; inst = '0; inst_ack = 1'b0; mem_ack = 1'b0;
    {z, c, n, v} = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (outs !== 22'h0) begin
        n_err++; $display("FAIL reset_outs cycle %0d: got %h want 000000", k, outs);
      end
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (inst_req !== 1'b1) begin
      n_err++; $display("FAIL reset_release_inst_req: got %b want 1", inst_req);
    end
  endtask

  task automatic test_alu();
    fetch(9'b0_0010_0000);
    n_cmp++;
    if (outs !== 22'h0) begin
      n_err++; $display("FAIL alu_decode_quiet: got %h want 000000", outs);
    end
    step();
    n_cmp++;
    if ({reg_write_en, reg_write_number, pc_inc, branch_en, reg_to_reg} !== {1'b1, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL alu_exec: got we=%b wn=%0d pc=%b br=%b r2r=%b want 1 0 1 0 0",
                        reg_write_en, reg_write_number, pc_inc, branch_en, reg_to_reg);
    end
    step();
    n_cmp++;
    if (inst_req !== 1'b1 || pc_inc !== 1'b0) begin
      n_err++; $display("FAIL alu_back_to_fetch: got req=%b pc=%b want 1 0", inst_req, pc_inc);
    end
  endtask

  task automatic test_load();
    int rd_cycles = 0;
    fetch(9'b0_0000_0101);
    step();
    n_cmp++;
    if ({memory_read_en, pc_inc, reg_write_en} !== 3'b000) begin
      n_err++; $display("FAIL load_exec_quiet: got rd=%b pc=%b we=%b want 0 0 0",
                        memory_read_en, pc_inc, reg_write_en);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      mem_ack = (k == 3);
      #1;
      if (memory_read_en === 1'b1) rd_cycles++;
      n_cmp++;
      if ({memory_read_en, reg_from_number, pc_inc, reg_write_en} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL load_mem cycle %0d: got rd=%b from=%0d pc=%b we=%b want 1 5 0 0",
                          k, memory_read_en, reg_from_number, pc_inc, reg_write_en);
      end
      step();
    end
    mem_ack = 1'b0;
    n_cmp++;
    if (rd_cycles != 4) begin
      n_err++; $display("FAIL load_read_len: got %0d want 4", rd_cycles);
    end
    n_cmp++;
    if ({reg_write_en, reg_write_number, pc_inc, memory_read_en} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL load_wb: got we=%b wn=%0d pc=%b rd=%b want 1 0 1 0",
                        reg_write_en, reg_write_number, pc_inc, memory_read_en);
    end
    step();
    n_cmp++;
    if (inst_req !== 1'b1) begin
      n_err++; $display("FAIL load_back_to_fetch: got %b want 1", inst_req);
    end
  endtask

  task automatic test_beq();
    for (int r = 0; r < 2; r++) begin
      logic zv;
      zv = (r == 0);
      fetch(9'b1_010_00111);
      z = zv;
      step();
      z = ~zv;
      n_cmp++;
      if ({branch_en, pc_inc, key} !== {zv, ~zv, (zv ? 5'd7 : 5'd0)}) begin
        n_err++; $display("FAIL beq z=%b: got br=%b pc=%b key=%0d want %b %b %0d",
                          zv, branch_en, pc_inc, key, zv, ~zv, zv ? 7 : 0);
      end
      step();
      z = 1'b0;
    end
  endtask

  task automatic test_branches();
    logic [8:0] ins   [0:7] = '{9'b1_101_00011, 9'b1_101_00011, 9'b1_110_00001, 9'b1_110_00001,
                                9'b1_000_00010, 9'b1_000_00010, 9'b1_001_00100, 9'b1_011_11111};
    logic [3:0] flg   [0:7] = '{4'b0000, 4'b1000, 4'b0100, 4'b0000,
                                4'b1010, 4'b0010, 4'b0000, 4'b0000};
    logic       exp_t [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      logic [8:0] cur;
      logic [4:0] exp_key;
      cur     = ins[k];
      exp_key = exp_t[k] ? cur[4:0] : 5'd0;
      fetch(cur);
      {z, c, n, v} = flg[k];
      step();
      {z, c, n, v} = ~flg[k];
      n_cmp++;
      if ({branch_en, pc_inc, key} !== {exp_t[k], ~exp_t[k], exp_key}) begin
        n_err++; $display("FAIL branch %0d inst=%b: got br=%b pc=%b key=%0d want %b %b %0d",
                          k, cur, branch_en, pc_inc, key, exp_t[k], ~exp_t[k], exp_key);
      end
      step();
      {z, c, n, v} = 4'b0000;
    end
  endtask

  task automatic test_acc_moves();
    // {fetch_acc_en, reg_write_en, reg_to_reg, wr_num, from_num, pc_inc, branch_en, key}
    logic [8:0]  ins [0:2] = '{9'b1_100_01010, 9'b0_1100_0110, 9'b0_1101_0010};
    logic [17:0] exp [0:2] = '{{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 5'd10},
                               {1'b0, 1'b1, 1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 5'd0},
                               {1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0, 5'd0}};
    for (int k = 0; k < 3; k++) begin
      logic [17:0] got;
      fetch(ins[k]);
      step();
      got = {fetch_acc_en, reg_write_en, reg_to_reg, reg_write_number, reg_from_number,
             pc_inc, branch_en, key};
      n_cmp++;
      if (got !== exp[k]) begin
        n_err++; $display("FAIL acc_move %0d: got %b want %b", k, got, exp[k]);
      end
      step();
    end
  endtask

  task automatic test_store();
    fetch(9'b0_0001_0011);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({pc_inc, memory_write_en, reg_write_en} !== 3'b000) begin
      n_err++; $display("FAIL store_stray_ack_exec: got pc=%b wr=%b we=%b want 0 0 0",
                        pc_inc, memory_write_en, reg_write_en);
    end
    step();
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if ({memory_write_en, pc_inc, reg_from_number, memory_read_en} !== {1'b1, 1'b1, 4'd3, 1'b0}) begin
      n_err++; $display("FAIL store_mem_ack: got wr=%b pc=%b from=%0d rd=%b want 1 1 3 0",
                        memory_write_en, pc_inc, reg_from_number, memory_read_en);
    end
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({inst_req, pc_inc, memory_write_en} !== 3'b100) begin
      n_err++; $display("FAIL store_back_to_fetch: got req=%b pc=%b wr=%b want 1 0 0",
                        inst_req, pc_inc, memory_write_en);
    end
  endtask

  task automatic test_store_reset();
    fetch(9'b0_0001_0011);
    step();
    step();
    n_cmp++;
    if (memory_write_en !== 1'b1) begin
      n_err++; $display("FAIL store_rst_mem1: got wr=%b want 1", memory_write_en);
    end
    step();
    reset   = 1'b1;
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (pc_inc !== 1'b0) begin
      n_err++; $display("FAIL store_rst_no_pc_inc: got %b want 0", pc_inc);
    end
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if (outs !== 22'h0) begin
      n_err++; $display("FAIL store_rst_dropped: got %h want 000000", outs);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({inst_req, memory_write_en, pc_inc} !== 3'b100) begin
      n_err++; $display("FAIL store_rst_refetch: got req=%b wr=%b pc=%b want 1 0 0",
                        inst_req, memory_write_en, pc_inc);
    end
  endtask

  task automatic test_halt();
    step();
    step();
    fetch(9'b0_0010_0000);
    step();
    step();
    fetch(9'b1_111_00000);
    step();
    n_cmp++;
    if (outs !== 22'h0) begin
      n_err++; $display("FAIL halt_exec_quiet: got %h want 000000", outs);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      inst_ack = k[0];
      mem_ack  = k[0];
      #1;
      n_cmp++;
      if (outs !== 22'h1) begin
        n_err++; $display("FAIL halt_hold cycle %0d: got %h want 000001", k, outs);
      end
`ifdef CTRL_PERF_CNT_EN
      n_cmp++;
      if (retired_cnt !== 32'd1 || stall_cnt !== 32'd2) begin
        n_err++; $display("FAIL halt_counters: got ret=%0d stall=%0d want 1 2", retired_cnt, stall_cnt);
      end
`endif
      step();
    end
    inst_ack = 1'b0;
    mem_ack  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_beq();
    test_branches();
    test_acc_moves();
    test_store();
    test_store_reset();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
